// File: rtl/gba_bk_pkg.sv
// Backup sequencer shared types.
// Sector/word defaults and FSM state encodings.
package gba_bk_pkg;

  localparam int SECTORS_DEF = 256;
  localparam int WORDS_DEF   = 256;

  typedef enum logic [2:0] {
    IDLE,
    L_SD,
    L_WAIT,
    L_XFER,
    S_XFER,
    S_SD,
    S_WAIT
  } bk_state_t;

  typedef enum logic [1:0] {
    X_IDLE,
    X_ADDR,
    X_REQ,
    X_WAIT
  } xfer_state_t;

endpackage

// File: rtl/gba_bk_word_xfer.sv
// Per-sector word mover between sector buffer and SDRAM.
// One word = address cycle, request cycle, wait for ready.
module gba_bk_word_xfer
  import gba_bk_pkg::*;
#(
  parameter int WORDS = WORDS_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic        start_save,
  input  logic [15:0] buf_rdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [7:0]  buf_addr,
  output logic        buf_we,
  output logic [15:0] buf_wdata,
  output logic        mem_req,
  output logic        mem_rnw,
  output logic [15:0] mem_wdata,
  output logic        done
);

  localparam logic [7:0] LAST = 8'(WORDS - 1);

  xfer_state_t xs_q, xs_d;
  logic [7:0]  addr_q, addr_d;
  logic        save_q;
  logic        active;

  // word-mover state, buffer address and latched direction
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      xs_q   <= X_IDLE;
      addr_q <= '0;
      save_q <= 1'b0;
    end else begin
      xs_q   <= xs_d;
      addr_q <= addr_d;
      if (start && xs_q == X_IDLE)
        save_q <= start_save;
    end
  end

  // next state, request pulse and buffer write strobe
  always_comb begin
    xs_d    = xs_q;
    addr_d  = addr_q;
    done    = 1'b0;
    buf_we  = 1'b0;
    mem_req = 1'b0;
    unique case (xs_q)
      X_IDLE: begin
        if (start) begin
          xs_d   = X_ADDR;
          addr_d = '0;
        end
      end
      X_ADDR: xs_d = X_REQ;
      X_REQ: begin
        mem_req = 1'b1;
        xs_d    = X_WAIT;
      end
      X_WAIT: begin
        if (mem_ready) begin
          buf_we = save_q;
          if (addr_q == LAST) begin
            done = 1'b1;
            xs_d = X_IDLE;
          end else begin
            addr_d = addr_q + 8'd1;
            xs_d   = X_ADDR;
          end
        end
      end
      default: xs_d = X_IDLE;
    endcase
  end

  assign active    = (xs_q != X_IDLE);
  assign buf_addr  = addr_q;
  assign mem_rnw   = active & save_q;
  assign buf_wdata = active ? mem_rdata : 16'h0;
  assign mem_wdata = (active && !save_q) ? buf_rdata : 16'h0;

endmodule

// File: rtl/gba_backup_seq.sv
// Backup RAM load/save sequencer (SD sector <-> SDRAM ch3).
// Owns trigger edges, bk_ena/pending and the sector FSM.
module gba_backup_seq
  import gba_bk_pkg::*;
#(
  parameter int SECTORS = SECTORS_DEF,
  parameter int WORDS   = WORDS_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        autosave_en,
  input  logic        osd_open,
  input  logic        save_write,
  input  logic        cart_download,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic        img_nonzero,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  output logic [7:0]  buf_addr,
  output logic        buf_we,
  output logic [15:0] buf_wdata,
  input  logic [15:0] buf_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  output logic        mem_rnw,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bk_ena,
  output logic        busy,
  output logic        loading,
  output logic        pending
);

  localparam logic [7:0] LAST_LBA = 8'(SECTORS - 1);

  bk_state_t  st_q, st_d;
  logic [7:0] lba_q, lba_d;
  logic       load_q, save_q, auto_q, dl_q, ack_q;
  logic       ld_trig_q, sv_trig_q;
  logic       bk_q, pend_q;
  logic       auto_now, ack_rise, ack_fall, last;
  logic       x_start, x_save, x_done, save_go;

  assign auto_now = pend_q & osd_open & autosave_en;
  assign ack_rise = sd_ack & ~ack_q;
  assign ack_fall = ~sd_ack & ack_q;
  assign last     = (lba_q == LAST_LBA);

  // edge history, registered triggers, sector state and lba
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      load_q    <= 1'b0;
      save_q    <= 1'b0;
      auto_q    <= 1'b0;
      dl_q      <= 1'b0;
      ack_q     <= 1'b0;
      ld_trig_q <= 1'b0;
      sv_trig_q <= 1'b0;
      st_q      <= IDLE;
      lba_q     <= '0;
    end else begin
      load_q    <= load_req;
      save_q    <= save_req;
      auto_q    <= auto_now;
      dl_q      <= cart_download;
      ack_q     <= sd_ack;
      ld_trig_q <= (load_req & ~load_q) |
                   (dl_q & ~cart_download & img_nonzero);
      sv_trig_q <= (save_req & ~save_q) |
                   (auto_now & ~auto_q);
      st_q      <= st_d;
      lba_q     <= lba_d;
    end
  end

  // image-available and unsaved-write flags
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      bk_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      if (cart_download & img_mounted & ~img_readonly)
        bk_q <= 1'b1;
      else if (cart_download & ~dl_q)
        bk_q <= 1'b0;
      if (save_go)
        pend_q <= 1'b0;
      else if (save_write & bk_q & ~osd_open)
        pend_q <= 1'b1;
    end
  end

  // sector FSM: load wins over save, triggers only taken in IDLE
  always_comb begin
    st_d    = st_q;
    lba_d   = lba_q;
    x_start = 1'b0;
    x_save  = 1'b0;
    save_go = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (bk_q & ld_trig_q) begin
          st_d = L_SD;
        end else if (bk_q & sv_trig_q) begin
          st_d    = S_XFER;
          x_start = 1'b1;
          x_save  = 1'b1;
          save_go = 1'b1;
        end
      end
      L_SD:   if (ack_rise) st_d = L_WAIT;
      L_WAIT: begin
        if (ack_fall) begin
          st_d    = L_XFER;
          x_start = 1'b1;
        end
      end
      L_XFER: begin
        if (x_done) begin
          if (last) begin
            st_d  = IDLE;
            lba_d = '0;
          end else begin
            st_d  = L_SD;
            lba_d = lba_q + 8'd1;
          end
        end
      end
      S_XFER: if (x_done) st_d = S_SD;
      S_SD:   if (ack_rise) st_d = S_WAIT;
      S_WAIT: begin
        if (ack_fall) begin
          if (last) begin
            st_d  = IDLE;
            lba_d = '0;
          end else begin
            st_d    = S_XFER;
            lba_d   = lba_q + 8'd1;
            x_start = 1'b1;
            x_save  = 1'b1;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  gba_bk_word_xfer #(
    .WORDS (WORDS)
  ) u_xfer (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .start      (x_start),
    .start_save (x_save),
    .buf_rdata  (buf_rdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .buf_addr   (buf_addr),
    .buf_we     (buf_we),
    .buf_wdata  (buf_wdata),
    .mem_req    (mem_req),
    .mem_rnw    (mem_rnw),
    .mem_wdata  (mem_wdata),
    .done       (x_done)
  );

  assign sd_lba   = {24'h0, lba_q};
  assign mem_addr = {lba_q, buf_addr};
  assign sd_rd    = (st_q == L_SD);
  assign sd_wr    = (st_q == S_SD);
  assign busy     = (st_q != IDLE);
  assign loading  = (st_q == L_SD) || (st_q == L_WAIT) ||
                    (st_q == L_XFER);
  assign bk_ena   = bk_q;
  assign pending  = pend_q;

endmodule

// File: tb/tb_gba_backup_seq.sv
// Bench for gba_backup_seq: SDRAM, buffer and HPS models,
// flag vector table plus load/save/abort sequences.
module tb_gba_backup_seq;

  localparam int NS = 8;
  localparam int NW = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_req = 1'b0, save_req = 1'b0;
  logic        autosave_en = 1'b0, osd_open = 1'b0;
  logic        save_write = 1'b0, cart_download = 1'b0;
  logic        img_mounted = 1'b0, img_readonly = 1'b0;
  logic        img_nonzero = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack = 1'b0;
  logic [7:0]  buf_addr;
  logic        buf_we;
  logic [15:0] buf_wdata;
  logic [15:0] buf_rdata = 16'h0;
  logic [15:0] mem_addr;
  logic        mem_req, mem_rnw;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_ready = 1'b0;
  logic        bk_ena, busy, loading, pending;

  gba_backup_seq #(.SECTORS(NS), .WORDS(NW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .load_req(load_req), .save_req(save_req),
    .autosave_en(autosave_en), .osd_open(osd_open),
    .save_write(save_write), .cart_download(cart_download),
    .img_mounted(img_mounted), .img_readonly(img_readonly),
    .img_nonzero(img_nonzero),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack),
    .buf_addr(buf_addr), .buf_we(buf_we),
    .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_rnw(mem_rnw), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bk_ena(bk_ena), .busy(busy),
    .loading(loading), .pending(pending)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_fail = 0;

  function automatic logic [15:0] pat(int l, int w);
    return {8'(l), 8'(w)} ^ 16'h5A3C;
  endfunction

  logic [15:0] sdram [0:65535];
  logic [15:0] bufm  [0:255];
  logic [15:0] img   [0:NS-1][0:NW-1];

  // SDRAM: ready two cycles after the request is captured
  int          s_cnt = 0;
  logic        s_pend = 1'b0;
  logic        s_rnw;
  logic [15:0] s_a, s_wd;
  always @(posedge clk_sys) begin
    mem_ready <= 1'b0;
    if (s_pend) begin
      if (s_cnt == 0) begin
        mem_ready <= 1'b1;
        if (s_rnw) mem_rdata <= sdram[s_a];
        else       sdram[s_a] <= s_wd;
        s_pend = 1'b0;
      end else begin
        s_cnt--;
      end
    end else if (mem_req) begin
      s_pend = 1'b1;
      s_cnt  = 1;
      s_a    = mem_addr;
      s_rnw  = mem_rnw;
      s_wd   = mem_wdata;
    end
  end

  // sector buffer (1-cycle read) and HPS sector port
  int         h_t = 0;
  logic       h_busy = 1'b0, h_rd;
  logic [7:0] h_lba;
  always @(posedge clk_sys) begin
    if (buf_we) bufm[buf_addr] <= buf_wdata;
    buf_rdata <= bufm[buf_addr];
    if (!h_busy) begin
      if (sd_rd || sd_wr) begin
        h_busy = 1'b1;
        h_t    = 0;
        h_rd   = sd_rd;
        h_lba  = sd_lba[7:0];
      end
    end else begin
      h_t++;
      if (h_t == 2) begin
        sd_ack <= 1'b1;
        for (int i = 0; i < NW; i++) begin
          if (h_rd) bufm[i] <= pat(h_lba, i);
          else      img[h_lba[2:0]][i] <= bufm[i];
        end
      end
      if (h_t == 5) sd_ack <= 1'b0;
      if (h_t == 7) h_busy = 1'b0;
    end
  end

  // activity monitor
  int   rd_cnt, wr_cnt, rreq, wreq, we_cnt, bsy_cnt;
  int   seq_err, ord_err, load_err;
  int   rd_exp, wr_exp, ord_l, ord_w;
  logic rd_p = 1'b0, wr_p = 1'b0, exp_loading = 1'b0;
  always @(negedge clk_sys) begin
    if (sd_rd && !rd_p) begin
      rd_cnt++;
      if (sd_lba != 32'(rd_exp)) seq_err++;
      rd_exp++;
    end
    if (sd_wr && !wr_p) begin
      wr_cnt++;
      if (sd_lba != 32'(wr_exp)) seq_err++;
      wr_exp++;
    end
    rd_p = sd_rd;
    wr_p = sd_wr;
    if (mem_req) begin
      if (mem_rnw) rreq++;
      else         wreq++;
      if (mem_addr != {8'(ord_l), 8'(ord_w)}) ord_err++;
      if (ord_w == NW - 1) begin
        ord_w = 0;
        ord_l++;
      end else begin
        ord_w++;
      end
    end
    if (buf_we) we_cnt++;
    if (busy) bsy_cnt++;
    if (busy && loading != exp_loading) load_err++;
  end

  task automatic clr();
    rd_cnt = 0; wr_cnt = 0; rreq = 0; wreq = 0;
    we_cnt = 0; bsy_cnt = 0; seq_err = 0; ord_err = 0;
    load_err = 0; rd_exp = 0; wr_exp = 0;
    ord_l = 0; ord_w = 0;
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    logic any;
    any = |{sd_lba, sd_rd, sd_wr, buf_addr, buf_we, buf_wdata,
            mem_addr, mem_req, mem_rnw, mem_wdata,
            bk_ena, busy, loading, pending};
    chk(nm, 32'(any), 32'd0);
  endtask

  task automatic wait_idle(int lim);
    int k = 0;
    while (busy && k < lim) begin
      tick(1);
      k++;
    end
    chk("idle_in_time", 32'(busy), 32'd0);
  endtask

  task automatic chk_sdram(input string nm);
    int e = 0;
    for (int l = 0; l < NS; l++)
      for (int w = 0; w < NW; w++)
        if (sdram[{8'(l), 8'(w)}] !== pat(l, w)) e++;
    chk(nm, 32'(e), 32'd0);
  endtask

  task automatic chk_img(input string nm);
    int e = 0;
    for (int l = 0; l < NS; l++)
      for (int w = 0; w < NW; w++)
        if (img[l][w] !== pat(l, w)) e++;
    chk(nm, 32'(e), 32'd0);
  endtask

  task automatic clr_img();
    for (int l = 0; l < NS; l++)
      for (int w = 0; w < NW; w++)
        img[l][w] = 16'h0;
  endtask

  task automatic mount_rw();
    img_nonzero   = 1'b0;
    cart_download = 1'b1;
    img_mounted   = 1'b1;
    img_readonly  = 1'b0;
    tick(1);
    img_mounted   = 1'b0;
    cart_download = 1'b0;
    tick(1);
  endtask

  typedef struct packed {
    logic dl, m, ro, sw, osd;
    logic ebk, ep;
  } vec_t;

  vec_t tbl [11];
  logic prev_p;
  int   k;

  initial begin
    tbl = '{
      '{0,0,0,0,0, 0,0},
      '{0,0,0,1,0, 0,0},
      '{1,1,1,0,0, 0,0},
      '{1,1,0,0,0, 1,0},
      '{0,0,0,0,0, 1,0},
      '{0,0,0,1,1, 1,0},
      '{0,0,0,1,0, 1,1},
      '{0,0,0,0,0, 1,1},
      '{1,0,0,0,0, 0,1},
      '{1,1,0,0,0, 1,1},
      '{0,0,0,0,0, 1,1}
    };
    for (int i = 0; i < 65536; i++) sdram[i] = 16'h0;
    for (int i = 0; i < 256; i++) bufm[i] = 16'h0;
    clr_img();
    clr();

    tick(3);
    chk_zero("reset_outs");
    reset_n = 1'b1;
    tick(1);
    chk_zero("post_reset_outs");

    for (int i = 0; i < 11; i++) begin
      cart_download = tbl[i].dl;
      img_mounted   = tbl[i].m;
      img_readonly  = tbl[i].ro;
      save_write    = tbl[i].sw;
      osd_open      = tbl[i].osd;
      tick(1);
      chk($sformatf("vec%0d_bk_ena", i), 32'(bk_ena),
          32'(tbl[i].ebk));
      chk($sformatf("vec%0d_pending", i), 32'(pending),
          32'(tbl[i].ep));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
    end
    save_write = 1'b0;

    // auto-load on download end
    clr();
    exp_loading   = 1'b1;
    img_nonzero   = 1'b1;
    cart_download = 1'b1;
    img_mounted   = 1'b1;
    tick(1);
    img_mounted   = 1'b0;
    tick(1);
    cart_download = 1'b0;
    tick(1);
    chk("dl_lat_busy0", 32'(busy), 32'd0);
    tick(1);
    chk("dl_busy1", 32'(busy), 32'd1);
    chk("dl_loading1", 32'(loading), 32'd1);
    chk("dl_sd_rd", 32'(sd_rd), 32'd1);
    img_nonzero = 1'b0;
    wait_idle(3000);
    chk("ld_sd_rd_cnt", 32'(rd_cnt), 32'(NS));
    chk("ld_lba_seq", 32'(seq_err), 32'd0);
    chk("ld_wreq_cnt", 32'(wreq), 32'(NS * NW));
    chk("ld_rreq_cnt", 32'(rreq), 32'd0);
    chk("ld_addr_order", 32'(ord_err), 32'd0);
    chk("ld_loading_hold", 32'(load_err), 32'd0);
    chk_sdram("ld_sdram_data");
    chk("ld_lba_end", sd_lba, 32'd0);
    chk("ld_loading_end", 32'(loading), 32'd0);

    // manual save clears pending as it starts
    clr();
    exp_loading = 1'b0;
    save_req = 1'b1;
    tick(1);
    chk("sv_pre_busy", 32'(busy), 32'd0);
    chk("sv_pre_pending", 32'(pending), 32'd1);
    tick(1);
    chk("sv_busy", 32'(busy), 32'd1);
    chk("sv_pending_clr", 32'(pending), 32'd0);
    save_req = 1'b0;
    wait_idle(3000);
    chk("sv_sd_wr_cnt", 32'(wr_cnt), 32'(NS));
    chk("sv_lba_seq", 32'(seq_err), 32'd0);
    chk("sv_rreq_cnt", 32'(rreq), 32'(NS * NW));
    chk("sv_wreq_cnt", 32'(wreq), 32'd0);
    chk("sv_buf_we_cnt", 32'(we_cnt), 32'(NS * NW));
    chk("sv_addr_order", 32'(ord_err), 32'd0);
    chk_img("sv_image");

    // autosave on OSD open
    clr();
    save_write = 1'b1;
    tick(1);
    save_write = 1'b0;
    chk("as_pending_set", 32'(pending), 32'd1);
    osd_open    = 1'b1;
    autosave_en = 1'b1;
    prev_p = pending;
    k = 0;
    while (k < 10) begin
      tick(1);
      if (busy) break;
      prev_p = pending;
      k++;
    end
    chk("as_started", 32'(busy), 32'd1);
    chk("as_prev_pending", 32'(prev_p), 32'd1);
    chk("as_pending_clr", 32'(pending), 32'd0);
    wait_idle(3000);
    chk("as_sd_wr_cnt", 32'(wr_cnt), 32'(NS));
    osd_open    = 1'b0;
    autosave_en = 1'b0;
    tick(2);

    // load and save together, save during load
    clr();
    exp_loading = 1'b1;
    load_req = 1'b1;
    save_req = 1'b1;
    tick(2);
    chk("both_load_wins", 32'(loading), 32'd1);
    tick(20);
    save_req = 1'b0;
    tick(2);
    save_req = 1'b1;
    tick(2);
    save_req = 1'b0;
    load_req = 1'b0;
    wait_idle(3000);
    tick(10);
    chk("both_idle", 32'(busy), 32'd0);
    chk("both_no_sd_wr", 32'(wr_cnt), 32'd0);
    chk("both_no_rreq", 32'(rreq), 32'd0);
    chk("both_sd_rd_cnt", 32'(rd_cnt), 32'(NS));
    exp_loading = 1'b0;

    // read-only mount blocks everything
    img_nonzero   = 1'b1;
    cart_download = 1'b1;
    img_mounted   = 1'b1;
    img_readonly  = 1'b1;
    tick(1);
    img_mounted   = 1'b0;
    img_readonly  = 1'b0;
    tick(1);
    cart_download = 1'b0;
    tick(1);
    chk("ro_bk_ena", 32'(bk_ena), 32'd0);
    clr();
    load_req = 1'b1;
    tick(10);
    load_req = 1'b0;
    chk("ro_no_busy", 32'(bsy_cnt), 32'd0);
    chk("ro_no_sd_rd", 32'(rd_cnt), 32'd0);
    mount_rw();
    chk("remount_bk_ena", 32'(bk_ena), 32'd1);

    // reset in sector 5 of a save, then restart
    clr();
    save_req = 1'b1;
    tick(1);
    save_req = 1'b0;
    k = 0;
    while (k < 2000 && !(mem_req && mem_addr[15:8] == 8'd5)) begin
      tick(1);
      k++;
    end
    chk("abort_reach_s5", 32'(mem_addr[15:8]), 32'd5);
    reset_n = 1'b0;
    tick(1);
    chk_zero("abort_outs");
    reset_n = 1'b1;
    tick(10);
    clr_img();
    mount_rw();
    clr();
    save_req = 1'b1;
    tick(2);
    save_req = 1'b0;
    chk("rs_busy", 32'(busy), 32'd1);
    chk("rs_lba0", sd_lba, 32'd0);
    wait_idle(3000);
    chk("rs_addr_order", 32'(ord_err), 32'd0);
    chk("rs_sd_wr_cnt", 32'(wr_cnt), 32'(NS));
    chk_img("rs_image");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gba_backup_seq.md
# gba_backup_seq

Sequencer for cartridge backup memory (Flash/EEPROM/SRAM image held in SDRAM channel 3) that moves the save image between the SD sector interface and SDRAM through a 256×16 sector buffer. It sits between the HPS sector port, the buffer, and SDRAM channel 3. It owns the load/save state machine, auto-load after cartridge download, and the autosave-pending flag. While loading, the CPU core is held off.

## Interface
Parameters:
- SECTORS, 256: sectors per image; sd_lba wraps after SECTORS-1.
- WORDS, 256: 16-bit words per sector (buffer depth).

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- load_req  in  1  OSD "Load Backup RAM"; acts on rising edge
- save_req  in  1  OSD "Save Backup RAM"; acts on rising edge
- autosave_en  in  1  autosave option
- osd_open  in  1  OSD currently shown
- save_write  in  1  CPU write into the backup region, 1-cycle pulse
- cart_download  in  1  cartridge download active
- img_mounted  in  1  save image mount strobe
- img_readonly  in  1  mounted image is read-only
- img_nonzero  in  1  mounted image size ≠ 0
- sd_lba  out  32  sector number (bits 31:8 always 0)
- sd_rd / sd_wr  out  1  sector read/write request
- sd_ack  in  1  HPS sector-transfer acknowledge
- buf_addr  out  8  buffer port-A address
- buf_we  out  1  buffer port-A write
- buf_wdata  out  16  buffer write data (= mem_rdata)
- buf_rdata  in  16  buffer read data, 1-cycle latency
- mem_addr  out  16  SDRAM ch3 word address {sd_lba[7:0], buf_addr}
- mem_req  out  1  1-cycle request pulse
- mem_rnw  out  1  1 = read (save), 0 = write (load)
- mem_wdata  out  16  = buf_rdata
- mem_rdata  in  16  SDRAM read data
- mem_ready  in  1  1-cycle completion strobe
- bk_ena  out  1  backup image available
- busy  out  1  state ≠ IDLE
- loading  out  1  load in progress (core reset)
- pending  out  1  unsaved writes exist (LED)

## Operation
- bk_ena: cleared on the rising edge of cart_download. Set when cart_download & img_mounted & ~img_readonly.
- pending: set by save_write & bk_ena & ~osd_open. Cleared in the cycle a save starts. If both occur in the same cycle, the clear wins.
- Triggers, accepted only in IDLE and only when bk_ena = 1:
  - rising edge of load_req;
  - rising edge of save_req;
  - rising edge of (pending & osd_open & autosave_en);
  - falling edge of cart_download with img_nonzero. This starts a load.
- A load trigger and a save trigger in the same cycle: load wins. Triggers outside IDLE are dropped, not queued.
- Load sequence, per sector:
  - L_SD: sd_rd = 1.
  - L_WAIT: wait for the falling edge of sd_ack.
  - L_XFER: for WORDS words, buffer → SDRAM write.
  - Then sd_lba++. Done after sector SECTORS-1.
- Save sequence, per sector:
  - S_XFER: for WORDS words, SDRAM read → buffer write.
  - S_SD: sd_wr = 1.
  - S_WAIT: wait for the falling edge of sd_ack.
  - Then sd_lba++. Done after sector SECTORS-1.
- sd_rd / sd_wr drop in the cycle after sd_ack is first seen rising. sd_ack edges in IDLE or XFER states are ignored.
- Word transfer: issue mem_req, wait for mem_ready, then advance buf_addr. buf_addr returns to 0 at the start of each XFER state.

## Timing
- Reset values: every output 0, except bk_ena, which is also 0. State = IDLE.
- Trigger edge seen at edge N → state leaves IDLE at edge N+1. busy and loading (for loads) are high from N+1.
- XFER per word:
  - cycle 0: buf_addr valid;
  - cycle 1: mem_req = 1 (buf_rdata now valid for loads);
  - then wait for mem_ready.
  - On mem_ready: save asserts buf_we with buf_wdata = mem_rdata in that same cycle, then buf_addr++ on the next edge.
  - Minimum 3 cycles per word.
- Last word (buf_addr = WORDS-1) with mem_ready → next state is the SD request (save) or the sector-advance (load). buf_addr does not wrap to 0 mid-sector.
- sd_lba[7:0] = 255 at completion → IDLE, and sd_lba is reset to 0.
- mem_ready arriving without an outstanding request is ignored.
- reset_n low mid-operation aborts immediately: all outputs return to reset values and the HPS handshake is abandoned.

## Structure
- Package gba_bk_pkg holds:
  - state enum: IDLE, L_SD, L_WAIT, L_XFER, S_XFER, S_SD, S_WAIT;
  - SECTORS_DEF and WORDS_DEF constants.
- Sub-module gba_bk_word_xfer contains the per-sector word-mover FSM: start/done, direction, buf/mem handshakes.
- Top level contains edge detectors, bk_ena/pending, and the sector FSM.
- The dual-port buffer stays outside this block.

## Test plan
- Download with img_mounted, writable, img_nonzero → falling edge of cart_download starts a load. Expect:
  - 256 sd_rd pulses with sd_lba 0..255;
  - 65536 mem_req with mem_rnw = 0;
  - loading high throughout, then busy = 0.
- save_req rising edge in IDLE → per sector, 256 SDRAM reads, then buf_we with mem_rdata, then sd_wr. mem_addr = {lba, word} increments monotonically 0..0xFFFF.
- save_write pulse with osd_open = 0 → pending = 1. Then osd_open = 1 with autosave_en = 1 → save starts and pending clears in the same cycle.
- load_req and save_req rising together → load only. save_req during a load → ignored; no save after the load finishes.
- img_readonly = 1 at mount → bk_ena = 0. load_req → no activity.
- reset_n low in the middle of sector 5 of a save → next cycle all outputs 0 and state IDLE. A following save starts again at sd_lba = 0.
